// File: rtl/dmem_responder_if.sv
// dmem_responder_if: bundles the CPU data-memory port and the request/grant backing bus that
// dmem_responder bridges.
//
// Signals
//   dmem_addr/dmem_rmask/dmem_wmask/dmem_wdata : load/store request from the memory stage
//   dmem_rdata/dmem_resp/dmem_err/dmem_ovf     : completion pulse, read data, error, overflow
//   bus_req/bus_we/bus_addr/bus_wstrb/bus_wdata : backing-bus request, held until granted
//   bus_gnt/bus_rvalid/bus_rdata               : backing-bus grant and read return
//
// Modports
//   slave  : the responder (consumes dmem requests, drives the backing bus)
//   master : the environment (CPU stage plus backing memory)
interface dmem_responder_if;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_err;
  logic        dmem_ovf;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata,
    output dmem_rdata, dmem_resp, dmem_err, dmem_ovf,
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output bus_gnt, bus_rvalid, bus_rdata,
    input  dmem_rdata, dmem_resp, dmem_err, dmem_ovf,
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the CPU data-memory port. Captures a single-cycle load or
// store request, runs it as one transaction on a request/grant backing bus and returns a
// one-cycle dmem_resp pulse carrying lane-masked load data.
//
// Ports
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   port : dmem_responder_if.slave (dmem request/response and backing-bus signals)
//
// Optional feature: define DMEM_TIMEOUT_EN to build a transaction timeout. Parameter TIMEOUT
// (default 64, minimum 2) then bounds the cycles spent in REQ plus WAIT_R; on expiry the
// request is abandoned and dmem_resp is returned with dmem_err set and zero data. Without
// the macro no counter exists, the block waits indefinitely and dmem_err is tied to 0.
module dmem_responder
`ifdef DMEM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 64
)
`endif
(
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  port
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ovf_q, ovf_d;

  logic        has_rd, has_wr, req_valid;
  logic        in_req, in_wait, in_resp;
  logic [31:0] lane_mask;
  logic        to_fire;

  assign has_rd    = |port.dmem_rmask;
  assign has_wr    = |port.dmem_wmask;
  assign req_valid = has_rd || has_wr;

  assign in_req  = (state_q == StReq);
  assign in_wait = (state_q == StWaitR);
  assign in_resp = (state_q == StResp);

  // Byte-lane expansion of the latched read mask; unselected lanes return 0x00.
  assign lane_mask = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            timeout;

  // cnt_q holds the number of cycles already spent in REQ/WAIT_R; the current cycle is the
  // last one allowed when cnt_q + 1 reaches TIMEOUT.
  assign timeout = (in_req || in_wait) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

  // A grant or read return in the final cycle still completes the transaction normally.
  assign to_fire = timeout && !((in_req && port.bus_gnt) || (in_wait && port.bus_rvalid));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == StIdle) begin
      // Cleared while idle so the count starts at zero on entry to REQ.
      cnt_d = '0;
      err_d = 1'b0;
    end else if (in_req || in_wait) begin
      cnt_d = cnt_q + CntW'(1);
      if (to_fire) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign port.dmem_err = in_resp && err_q;
`else
  assign to_fire       = 1'b0;
  assign port.dmem_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          // A request with both masks set is carried out as a store and flagged.
          addr_d  = port.dmem_addr;
          we_d    = has_wr;
          wstrb_d = has_wr ? port.dmem_wmask : port.dmem_rmask;
          wdata_d = port.dmem_wdata;
          rdata_d = '0;
          state_d = StReq;
          if (has_rd && has_wr) begin
            ovf_d = 1'b1;
          end
        end
      end
      StReq: begin
        if (port.bus_gnt) begin
          state_d = we_q ? StResp : StWaitR;
        end else if (to_fire) begin
          state_d = StResp;
        end
      end
      StWaitR: begin
        if (port.bus_rvalid) begin
          rdata_d = port.bus_rdata & lane_mask;
          state_d = StResp;
        end else if (to_fire) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Only one transaction is tracked; anything arriving while busy is lost.
    if (req_valid && (state_q != StIdle)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
    end
  end

  // Bus outputs are only presented while requesting so they read as zero otherwise.
  assign port.bus_req   = in_req;
  assign port.bus_we    = in_req && we_q;
  assign port.bus_addr  = in_req ? addr_q : '0;
  assign port.bus_wstrb = in_req ? wstrb_q : '0;
  assign port.bus_wdata = in_req ? wdata_q : '0;

  assign port.dmem_resp  = in_resp;
  assign port.dmem_rdata = in_resp ? rdata_q : '0;
  assign port.dmem_ovf   = ovf_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;

  dmem_responder_if bus_if ();

  always #5 clk = ~clk;

`ifdef DMEM_TIMEOUT_EN
  dmem_responder #(.TIMEOUT(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bus_if.slave)
  );
`else
  dmem_responder dut (
    .clk  (clk),
    .rst  (rst),
    .port (bus_if.slave)
  );
`endif

  int checks = 0;
  int errors = 0;
  int grants = 0;

  // Scoreboard entries: {expected dmem_rdata, expected dmem_err}.
  logic [32:0] exp_q[$];
  logic [32:0] sb_exp;
  logic        resp_last = 1'b0;

  // Response monitor: every dmem_resp pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst) begin
      resp_last = 1'b0;
    end else begin
      if (bus_if.bus_req && bus_if.bus_gnt) grants++;
      if (bus_if.dmem_resp) begin
        checks++;
        if (resp_last) begin
          errors++;
          $display("FAIL resp_width: dmem_resp high in consecutive cycles, required one-cycle pulse");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got rdata=%h err=%b, required no response",
                   bus_if.dmem_rdata, bus_if.dmem_err);
        end else begin
          sb_exp = exp_q.pop_front();
          if ({bus_if.dmem_rdata, bus_if.dmem_err} !== sb_exp) begin
            errors++;
            $display("FAIL resp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                     bus_if.dmem_rdata, bus_if.dmem_err, sb_exp[32:1], sb_exp[0]);
          end
        end
      end
      resp_last = bus_if.dmem_resp;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.dmem_addr  = '0;
    bus_if.dmem_rmask = '0;
    bus_if.dmem_wmask = '0;
    bus_if.dmem_wdata = '0;
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = '0;
  endtask

  task automatic apply_reset();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb} !== 6'b0) begin
      errors++;
      $display("FAIL reset_bus_ctrl: got %b, required 000000",
               {bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb});
    end
    checks++;
    if ({bus_if.bus_addr, bus_if.bus_wdata, bus_if.dmem_rdata} !== 96'b0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, required all 0",
               bus_if.bus_addr, bus_if.bus_wdata, bus_if.dmem_rdata);
    end
    checks++;
    if ({bus_if.dmem_resp, bus_if.dmem_err, bus_if.dmem_ovf} !== 3'b0) begin
      errors++;
      $display("FAIL reset_dmem_flags: got %b, required 000",
               {bus_if.dmem_resp, bus_if.dmem_err, bus_if.dmem_ovf});
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_store();
    cyc();
    bus_if.dmem_addr  = 32'h0000_1004;
    bus_if.dmem_wmask = 4'b1100;
    bus_if.dmem_wdata = 32'hABCD_0000;
    exp_q.push_back({32'h0, 1'b0});
    cyc();
    bus_if.dmem_wmask = '0;
    bus_if.bus_gnt    = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb, bus_if.bus_addr, bus_if.bus_wdata} !==
        {1'b1, 1'b1, 4'b1100, 32'h0000_1004, 32'hABCD_0000}) begin
      errors++;
      $display("FAIL store_bus: got req=%b we=%b wstrb=%b addr=%h wdata=%h, required 1 1 1100 00001004 abcd0000",
               bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb, bus_if.bus_addr,
               bus_if.bus_wdata);
    end
    cyc();
    bus_if.bus_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.dmem_resp !== 1'b1) begin
      errors++;
      $display("FAIL store_latency: got dmem_resp=%b in cycle 2, required 1", bus_if.dmem_resp);
    end
    cyc();
  endtask

  task automatic test_load();
    int req_cycles;
    int pulses;
    cyc();
    bus_if.dmem_addr  = 32'h0000_2008;
    bus_if.dmem_rmask = 4'b0010;
    exp_q.push_back({32'h0000_3300, 1'b0});
    cyc();
    bus_if.dmem_rmask = '0;
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      bus_if.bus_gnt    = (i == 3);
      // Stray read data while still requesting must be ignored.
      bus_if.bus_rvalid = (i == 1);
      bus_if.bus_rdata  = (i == 1) ? 32'hFFFF_FFFF : 32'h0;
      @(negedge clk);
      if (bus_if.bus_req) req_cycles++;
      if (i == 0) begin
        checks++;
        if ({bus_if.bus_we, bus_if.bus_wstrb, bus_if.bus_addr} !== {1'b0, 4'b0010, 32'h0000_2008}) begin
          errors++;
          $display("FAIL load_bus: got we=%b wstrb=%b addr=%h, required 0 0010 00002008",
                   bus_if.bus_we, bus_if.bus_wstrb, bus_if.bus_addr);
        end
      end
      cyc();
    end
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    @(negedge clk);
    if (bus_if.bus_req) req_cycles++;
    checks++;
    if (req_cycles != 4) begin
      errors++;
      $display("FAIL load_req_cycles: got %0d, required 4", req_cycles);
    end
    cyc();
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h1122_3344;
    cyc();
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = '0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_if.dmem_resp) pulses++;
      cyc();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL load_pulses: got %0d dmem_resp pulses, required 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    bus_if.dmem_addr  = 32'h0000_3000;
    bus_if.dmem_rmask = 4'b1001;
    exp_q.push_back({32'hAA00_00DD, 1'b0});
    cyc();
    bus_if.dmem_rmask = '0;
    bus_if.bus_gnt    = 1'b1;
    cyc();
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'hAABB_CCDD;
    cyc();
    bus_if.bus_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.dmem_resp !== 1'b1) begin
      errors++;
      $display("FAIL load_latency: got dmem_resp=%b in cycle 3, required 1", bus_if.dmem_resp);
    end
    cyc();
    bus_if.dmem_addr  = 32'h0000_3004;
    bus_if.dmem_wmask = 4'b0001;
    bus_if.dmem_wdata = 32'h0000_0055;
    exp_q.push_back({32'h0, 1'b0});
    cyc();
    bus_if.dmem_wmask = '0;
    bus_if.bus_gnt    = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr} !== {1'b1, 1'b1, 32'h0000_3004}) begin
      errors++;
      $display("FAIL b2b_accept: got req=%b we=%b addr=%h, required 1 1 00003004",
               bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr);
    end
    cyc();
    bus_if.bus_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_if.dmem_resp, bus_if.dmem_ovf} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_resp_ovf: got resp=%b ovf=%b, required resp=1 ovf=0",
               bus_if.dmem_resp, bus_if.dmem_ovf);
    end
    cyc();
  endtask

  task automatic test_drop_wait_r();
    int g0;
    int req_cycles;
    g0 = grants;
    cyc();
    bus_if.dmem_addr  = 32'h0000_5000;
    bus_if.dmem_rmask = 4'b1111;
    exp_q.push_back({32'h0BAD_F00D, 1'b0});
    cyc();
    bus_if.dmem_rmask = '0;
    bus_if.bus_gnt    = 1'b1;
    cyc();
    bus_if.bus_gnt    = 1'b0;
    bus_if.dmem_addr  = 32'h0000_5008;
    bus_if.dmem_wmask = 4'b0011;
    bus_if.dmem_wdata = 32'h0000_1234;
    cyc();
    bus_if.dmem_wmask = '0;
    @(negedge clk);
    checks++;
    if ({bus_if.dmem_ovf, bus_if.bus_req} !== 2'b10) begin
      errors++;
      $display("FAIL drop_wait_r_ovf: got ovf=%b bus_req=%b, required ovf=1 bus_req=0",
               bus_if.dmem_ovf, bus_if.bus_req);
    end
    cyc();
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h0BAD_F00D;
    cyc();
    bus_if.bus_rvalid = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_if.bus_req) req_cycles++;
      cyc();
    end
    checks++;
    if (req_cycles != 0 || grants - g0 != 1) begin
      errors++;
      $display("FAIL drop_no_extra_txn: got %0d extra req cycles and %0d grants, required 0 and 1",
               req_cycles, grants - g0);
    end
    checks++;
    if (bus_if.dmem_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got dmem_ovf=%b, required 1", bus_if.dmem_ovf);
    end
  endtask

  task automatic test_async_reset();
    int pulses;
    int req_cycles;
    cyc();
    bus_if.dmem_addr  = 32'h0000_6000;
    bus_if.dmem_rmask = 4'b0001;
    cyc();
    bus_if.dmem_rmask = '0;
    bus_if.bus_gnt    = 1'b1;
    cyc();
    bus_if.bus_gnt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_if.bus_req, bus_if.dmem_resp, bus_if.dmem_ovf} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got req=%b resp=%b ovf=%b mid-cycle, required 000",
               bus_if.bus_req, bus_if.dmem_resp, bus_if.dmem_ovf);
    end
    cyc();
    rst = 1'b0;
    cyc();
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h5555_AAAA;
    cyc();
    bus_if.bus_rvalid = 1'b0;
    pulses     = 0;
    req_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_if.dmem_resp) pulses++;
      if (bus_if.bus_req) req_cycles++;
      cyc();
    end
    checks++;
    if (pulses != 0 || req_cycles != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: got %0d resp pulses and %0d req cycles, required 0 and 0",
               pulses, req_cycles);
    end
  endtask

  task automatic test_both_masks();
    cyc();
    bus_if.dmem_addr  = 32'h0000_7000;
    bus_if.dmem_rmask = 4'b0011;
    bus_if.dmem_wmask = 4'b1100;
    bus_if.dmem_wdata = 32'hCAFE_0000;
    exp_q.push_back({32'h0, 1'b0});
    cyc();
    bus_if.dmem_rmask = '0;
    bus_if.dmem_wmask = '0;
    bus_if.bus_gnt    = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_if.bus_we, bus_if.bus_wstrb, bus_if.dmem_ovf} !== {1'b1, 4'b1100, 1'b1}) begin
      errors++;
      $display("FAIL both_masks: got we=%b wstrb=%b ovf=%b, required 1 1100 1",
               bus_if.bus_we, bus_if.bus_wstrb, bus_if.dmem_ovf);
    end
    cyc();
    bus_if.bus_gnt = 1'b0;
    cyc();
  endtask

  task automatic test_drop_resp_cycle();
    int req_cycles;
    apply_reset();
    cyc();
    bus_if.dmem_addr  = 32'h0000_4000;
    bus_if.dmem_wmask = 4'b1111;
    bus_if.dmem_wdata = 32'h1234_5678;
    exp_q.push_back({32'h0, 1'b0});
    cyc();
    bus_if.dmem_wmask = '0;
    bus_if.bus_gnt    = 1'b1;
    cyc();
    bus_if.bus_gnt    = 1'b0;
    bus_if.dmem_addr  = 32'h0000_4004;
    bus_if.dmem_rmask = 4'b0100;
    cyc();
    bus_if.dmem_rmask = '0;
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_if.bus_req) req_cycles++;
      cyc();
    end
    checks++;
    if (req_cycles != 0 || bus_if.dmem_ovf !== 1'b1) begin
      errors++;
      $display("FAIL drop_resp_cycle: got %0d req cycles ovf=%b, required 0 req cycles ovf=1",
               req_cycles, bus_if.dmem_ovf);
    end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    int req_cycles;
    int pulses;
    apply_reset();
    cyc();
    bus_if.dmem_addr  = 32'h0000_8000;
    bus_if.dmem_rmask = 4'b1111;
    exp_q.push_back({32'h0, 1'b1});
    cyc();
    bus_if.dmem_rmask = '0;
    req_cycles = 0;
    pulses     = 0;
    for (int i = 0; i < 14; i++) begin
      bus_if.bus_rvalid = (i == 10);
      bus_if.bus_rdata  = (i == 10) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge clk);
      if (bus_if.bus_req) req_cycles++;
      if (bus_if.dmem_resp) pulses++;
      cyc();
    end
    bus_if.bus_rvalid = 1'b0;
    checks++;
    if (req_cycles != 8 || pulses != 1) begin
      errors++;
      $display("FAIL timeout: got %0d req cycles and %0d resp pulses, required 8 and 1",
               req_cycles, pulses);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_drop_wait_r();
    test_async_reset();
    test_both_masks();
    test_drop_resp_cycle();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_resp: got %0d outstanding expected responses, required 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

endmodule
